// File: rtl/edit_field_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : edit_field_ctrl
//  Purpose  : Front-end control for the BCD time/date/timer counters.
//             Synchronises the raw switches and push-buttons, debounces the
//             buttons, tracks the field being edited (F0/F1/F2 within the
//             group picked by sw_sel) and drives the shared counter enables.
//  Ports    : clk        - system clock
//             reset      - asynchronous, active-low reset
//             sw_prog    - 1 = programming mode, 0 = run (no edits)
//             sw_sel     - group: 00 clock, 01 date, 10 timer, 11 invalid
//             btn_up     - raw button, step selected field up
//             btn_down   - raw button, step selected field down
//             btn_left   - raw button, previous field
//             btn_right  - raw button, next field
//             en_count   - code of the field allowed to change, 0 = none
//             enUP       - selected counter increments while high
//             enDOWN     - selected counter decrements while high
//  Revision : 1.0  initial release
// ============================================================================
module edit_field_ctrl #(
    parameter int              CNT_W        = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CNT = 20'd999_999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_prog,
    input  logic [1:0] sw_sel,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN
);

    // Button slots inside the debounced vector
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_F0   = 2'd1;
    localparam logic [1:0] S_F1   = 2'd2;
    localparam logic [1:0] S_F2   = 2'd3;

    // ------------------------------------------------------------------
    // Two-flop synchroniser on every raw input
    // ------------------------------------------------------------------
    logic [6:0] w_raw;
    logic [6:0] r_sync1;
    logic [6:0] r_sync2;

    assign w_raw = {btn_right, btn_left, btn_down, btn_up, sw_sel, sw_prog};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 7'd0;
            r_sync2 <= 7'd0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    logic       w_prog;
    logic [1:0] w_sel;
    logic [3:0] w_btn;

    assign w_prog = r_sync2[0];
    assign w_sel  = r_sync2[2:1];
    assign w_btn  = r_sync2[6:3];

    // ------------------------------------------------------------------
    // Debounce: a level is accepted only after the synced input has
    // disagreed with it for DEBOUNCE_CNT+1 consecutive cycles; any
    // agreement in between restarts the count.
    // ------------------------------------------------------------------
    logic [3:0] w_db;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_db
            logic [CNT_W-1:0] r_cnt;
            logic             r_lvl;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (w_btn[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == DEBOUNCE_CNT) begin
                    r_lvl <= ~r_lvl;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end

            assign w_db[gi] = r_lvl;
        end
    endgenerate

    // Rising-edge pulses for navigation; a held button yields one pulse
    logic [3:0] r_db_d;
    logic [3:0] w_rise;
    logic       w_left;
    logic       w_right;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_d <= 4'd0;
        end else begin
            r_db_d <= w_db;
        end
    end

    assign w_rise  = w_db & ~r_db_d;
    assign w_left  = w_rise[BTN_LEFT];
    assign w_right = w_rise[BTN_RIGHT];

    // Previous synced group, used to detect a group change while editing
    logic [1:0] r_sel_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_d <= 2'd0;
        end else begin
            r_sel_d <= w_sel;
        end
    end

    // ------------------------------------------------------------------
    // Field FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_prog) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE) begin
            w_state_nxt = S_F0;
        end else if (w_sel != r_sel_d) begin
            w_state_nxt = S_F0;
        end else if (w_right && !w_left) begin
            case (r_state)
                S_F0:    w_state_nxt = S_F1;
                S_F1:    w_state_nxt = S_F2;
                default: w_state_nxt = S_F0;
            endcase
        end else if (w_left && !w_right) begin
            case (r_state)
                S_F0:    w_state_nxt = S_F2;
                S_F2:    w_state_nxt = S_F1;
                default: w_state_nxt = S_F0;
            endcase
        end
    end

    // Outputs are decoded from the next state so that a field change and
    // the enables that depend on it land on the same clock edge.
    logic [3:0] w_base;
    logic [1:0] w_field;
    logic [3:0] w_en_nxt;
    logic       w_up_nxt;
    logic       w_dn_nxt;

    always_comb begin
        w_base   = 4'd0;
        w_field  = w_state_nxt - 2'd1;
        w_en_nxt = 4'd0;
        case (w_sel)
            2'b00:   w_base = 4'd1;
            2'b01:   w_base = 4'd4;
            2'b10:   w_base = 4'd10;
            default: w_base = 4'd0;
        endcase
        if ((w_state_nxt != S_IDLE) && (w_sel != 2'b11)) begin
            w_en_nxt = w_base + {2'b00, w_field};
        end
        w_up_nxt = w_db[BTN_UP] & ~w_db[BTN_DOWN] &
                   (w_state_nxt != S_IDLE) & (w_en_nxt != 4'd0);
        w_dn_nxt = w_db[BTN_DOWN] & ~w_db[BTN_UP] &
                   (w_state_nxt != S_IDLE) & (w_en_nxt != 4'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_count <= 4'd0;
            enUP     <= 1'b0;
            enDOWN   <= 1'b0;
        end else begin
            en_count <= w_en_nxt;
            enUP     <= w_up_nxt;
            enDOWN   <= w_dn_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edit_field_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edit_field_ctrl
//  Purpose  : Self-checking bench for edit_field_ctrl with a short debounce
//             window, directed scenarios plus a randomized run, all checked
//             against a behavioural model of the field/enable rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_edit_field_ctrl;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_prog = 1'b0;
    logic [1:0] sw_sel = 2'd0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;

    int n_checks = 0;
    int n_fail   = 0;

    edit_field_ctrl #(
        .CNT_W       (20),
        .DEBOUNCE_CNT(20'd4)
    ) u_dut (
        .clk      (clk),
        .reset    (rst_n),
        .sw_prog  (sw_prog),
        .sw_sel   (sw_sel),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .en_count (en_count),
        .enUP     (enUP),
        .enDOWN   (enDOWN)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Inputs as seen after the two-cycle synchroniser delay; buttons
    // indexed 0 up, 1 down, 2 left, 3 right.
    typedef struct {
        bit prog;
        int sel;
        bit b[4];
    } in_t;

    in_t q[$];
    int  m_code[4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{10, 11, 12}, '{0, 0, 0}};
    int  m_run[4];
    bit  m_lvl[4];
    bit  m_rose[4];
    int  m_field;       // -1 means not editing
    int  m_sel_seen;
    logic [3:0] m_en;
    logic       m_up;
    logic       m_dn;

    function automatic in_t cur_in();
        in_t x;
        x.prog = sw_prog;
        x.sel  = int'(sw_sel);
        x.b[0] = btn_up;
        x.b[1] = btn_down;
        x.b[2] = btn_left;
        x.b[3] = btn_right;
        return x;
    endfunction

    task automatic model_reset();
        in_t z;
        z.prog = 0; z.sel = 0;
        for (int i = 0; i < 4; i++) z.b[i] = 0;
        q = {};
        q.push_back(z);
        q.push_back(z);
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0; m_lvl[i] = 0; m_rose[i] = 0;
        end
        m_field = -1;
        m_sel_seen = 0;
        m_en = 4'd0; m_up = 1'b0; m_dn = 1'b0;
    endtask

    task automatic model_edge();
        in_t s;
        int  nf;
        bit  old;
        s = q[0];
        if (!s.prog)                          nf = -1;
        else if (m_field < 0)                 nf = 0;
        else if (s.sel != m_sel_seen)         nf = 0;
        else if (m_rose[3] && !m_rose[2])     nf = (m_field + 1) % 3;
        else if (m_rose[2] && !m_rose[3])     nf = (m_field + 2) % 3;
        else                                  nf = m_field;
        m_en = (nf < 0) ? 4'd0 : 4'(m_code[s.sel][nf]);
        m_up = m_lvl[0] && !m_lvl[1] && (m_en != 0);
        m_dn = m_lvl[1] && !m_lvl[0] && (m_en != 0);
        m_field = nf;
        m_sel_seen = s.sel;
        for (int i = 0; i < 4; i++) begin
            old = m_lvl[i];
            if (s.b[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DC + 1) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_rose[i] = m_lvl[i] && !old;
        end
        void'(q.pop_front());
        q.push_back(cur_in());
    endtask

    // One clock: update the model at the edge, return 1 ns later
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (en_count !== 4'd0 || enUP !== 1'b0 || enDOWN !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d en_count=%0d enUP=%b enDOWN=%b want 0/0/0",
                         i, en_count, enUP, enDOWN);
            end
        end
    endtask

    task automatic test_up_press();
        int n;
        sw_prog = 1'b1; sw_sel = 2'b10;
        n = 0;
        do begin step(); n++; end while (en_count !== 4'd10 && n < 20);
        n_checks++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL sw_latency got=%0d cycles want=3 (en_count=%0d)", n, en_count);
        end
        repeat (2) step();
        btn_up = 1'b1;
        n = 0;
        do begin step(); n++; end while (enUP !== 1'b1 && n < 30);
        n_checks++;
        if (n != DC + 4) begin
            n_fail++;
            $display("FAIL press_latency got=%0d cycles want=%0d", n, DC + 4);
        end
        btn_up = 1'b0;
        n = 0;
        do begin step(); n++; end while (enUP !== 1'b0 && n < 30);
        n_checks++;
        if (n != DC + 4) begin
            n_fail++;
            $display("FAIL release_latency got=%0d cycles want=%0d", n, DC + 4);
        end
        repeat (3) step();
    endtask

    task automatic test_bounce();
        int n;
        for (int t = 0; t < 10; t++) begin
            btn_up = ~btn_up;
            for (int k = 0; k < 3; k++) begin
                step();
                n_checks++;
                if (enUP !== 1'b0 || enUP !== m_up) begin
                    n_fail++;
                    $display("FAIL bounce_reject t=%0d enUP=%b want 0", t, enUP);
                end
            end
        end
        btn_up = 1'b1;
        n = 0;
        do begin step(); n++; end while (enUP !== 1'b1 && n < 30);
        n_checks++;
        if (n != DC + 4) begin
            n_fail++;
            $display("FAIL bounce_settle got=%0d cycles want=%0d", n, DC + 4);
        end
        btn_up = 1'b0;
        repeat (10) step();
    endtask

    task automatic press(input int which);
        if (which == 2) btn_left = 1'b1; else btn_right = 1'b1;
        repeat (DC + 4) step();
    endtask

    task automatic test_nav();
        logic [3:0] exp_seq[3] = '{4'd2, 4'd3, 4'd1};
        sw_sel = 2'b00;
        repeat (5) step();
        n_checks++;
        if (en_count !== 4'd1) begin
            n_fail++;
            $display("FAIL nav_start en_count=%0d want 1", en_count);
        end
        for (int i = 0; i < 3; i++) begin
            press(3);
            n_checks++;
            if (en_count !== exp_seq[i] || en_count !== m_en) begin
                n_fail++;
                $display("FAIL nav_right i=%0d en_count=%0d want %0d", i, en_count, exp_seq[i]);
            end
            btn_right = 1'b0;
            repeat (10) step();
        end
        press(2);
        n_checks++;
        if (en_count !== 4'd3) begin
            n_fail++;
            $display("FAIL nav_left en_count=%0d want 3", en_count);
        end
        btn_left = 1'b0;
        repeat (10) step();
        btn_left = 1'b1; btn_right = 1'b1;
        repeat (12) step();
        n_checks++;
        if (en_count !== 4'd3) begin
            n_fail++;
            $display("FAIL nav_both en_count=%0d want 3", en_count);
        end
        btn_left = 1'b0; btn_right = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_group_switch();
        sw_sel = 2'b10;
        repeat (3) step();
        n_checks++;
        if (en_count !== 4'd10) begin
            n_fail++;
            $display("FAIL grp_timer en_count=%0d want 10", en_count);
        end
        press(2);
        n_checks++;
        if (en_count !== 4'd12) begin
            n_fail++;
            $display("FAIL grp_f2 en_count=%0d want 12", en_count);
        end
        btn_left = 1'b0;
        repeat (8) step();
        btn_up = 1'b1;
        repeat (DC + 4) step();
        sw_sel = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (enUP !== 1'b1 || enDOWN !== 1'b0) begin
                n_fail++;
                $display("FAIL grp_no_glitch cyc=%0d enUP=%b enDOWN=%b want 1/0", i, enUP, enDOWN);
            end
        end
        n_checks++;
        if (en_count !== 4'd4) begin
            n_fail++;
            $display("FAIL grp_date en_count=%0d want 4", en_count);
        end
        sw_sel = 2'b11;
        repeat (3) step();
        n_checks++;
        if (en_count !== 4'd0 || enUP !== 1'b0) begin
            n_fail++;
            $display("FAIL grp_invalid en_count=%0d enUP=%b want 0/0", en_count, enUP);
        end
    endtask

    task automatic test_both_and_reset();
        sw_sel = 2'b00;
        repeat (3) step();
        btn_down = 1'b1;
        repeat (DC + 4) step();
        n_checks++;
        if (enUP !== 1'b0 || enDOWN !== 1'b0 || en_count !== 4'd1) begin
            n_fail++;
            $display("FAIL both_held en=%0d enUP=%b enDOWN=%b want 1/0/0", en_count, enUP, enDOWN);
        end
        btn_up = 1'b0;
        repeat (DC + 4) step();
        n_checks++;
        if (enDOWN !== 1'b1 || enUP !== 1'b0) begin
            n_fail++;
            $display("FAIL down_only enUP=%b enDOWN=%b want 0/1", enUP, enDOWN);
        end
        sw_prog = 1'b0;
        repeat (3) step();
        n_checks++;
        if (en_count !== 4'd0 || enDOWN !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_off en_count=%0d enDOWN=%b want 0/0", en_count, enDOWN);
        end
        sw_prog = 1'b1;
        repeat (3) step();
        btn_down = 1'b0;
        btn_up = 1'b1;
        repeat (DC + 4) step();
        btn_down = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (en_count !== 4'd0 || enUP !== 1'b0 || enDOWN !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset en_count=%0d enUP=%b enDOWN=%b want 0/0/0", en_count, enUP, enDOWN);
        end
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            n_checks++;
            if (enUP !== 1'b0 || enDOWN !== 1'b0 || en_count !== m_en) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d en=%0d/%0d enUP=%b enDOWN=%b", i, en_count, m_en, enUP, enDOWN);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) sw_prog = ~sw_prog;
            if (!sw_prog && $urandom_range(0, 19) == 0) sw_prog = 1'b1;
            if ($urandom_range(0, 59) == 0) sw_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 9) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 11) == 0) btn_left = ~btn_left;
            if ($urandom_range(0, 11) == 0) btn_right = ~btn_right;
            step();
            n_checks++;
            if (en_count !== m_en || enUP !== m_up || enDOWN !== m_dn || (enUP & enDOWN) !== 1'b0) begin
                n_fail++;
                $display("FAIL random_model c=%0d en=%0d/%0d enUP=%b/%b enDOWN=%b/%b",
                         c, en_count, m_en, enUP, m_up, enDOWN, m_dn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_press();
        test_bounce();
        test_nav();
        test_group_switch();
        test_both_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
